// File: rtl/cnn_pkg.sv
// Shared defaults and reader state encoding for the CNN frame feeder.
package cnn_pkg;

    localparam int DEF_DATA_W   = 8;
    localparam int DEF_IMG_W    = 28;
    localparam int DEF_IMG_H    = 28;
    localparam int DEF_CHANNELS = 1;
    localparam int DEF_CLASS_W  = 4;

    typedef enum logic [1:0] {
        IDLE,
        START,
        RUN,
        RESULT
    } feeder_state_t;

endpackage

// File: rtl/frame_bank_ram.sv
// Two-bank pixel store: one write port, one registered read port, bank chosen by address MSB.
module frame_bank_ram #(
    parameter int DATA_W = 8,
    parameter int N      = 784,
    parameter int ADDR_W = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              wr_bank,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_bank,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int              DEPTH = 2 ** (ADDR_W + 1);
    localparam logic [ADDR_W:0] N_LIM = (ADDR_W + 1)'(N);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{wr_bank, wr_addr}] <= wr_data;
        end
    end

    // Addresses past the frame read as zero so the core sees clean padding.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data <= '0;
        end else if ({1'b0, rd_addr} < N_LIM) begin
            rd_data <= mem[{rd_bank, rd_addr}];
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: rtl/cnn_frame_feeder.sv
// Ping-pong frame buffer and run controller feeding the cnn core.
//   state  | meaning
//   IDLE   | waiting for the read bank to fill
//   START  | one-cycle start pulse to the core
//   RUN    | core enabled, waiting for cnn_done
//   RESULT | holding classification until res_ready
module cnn_frame_feeder
    import cnn_pkg::*;
#(
    parameter  int DATA_W   = DEF_DATA_W,
    parameter  int IMG_W    = DEF_IMG_W,
    parameter  int IMG_H    = DEF_IMG_H,
    parameter  int CHANNELS = DEF_CHANNELS,
    parameter  int CLASS_W  = DEF_CLASS_W,
    localparam int N        = IMG_W * IMG_H * CHANNELS,
    localparam int ADDR_W   = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s_valid,
    input  logic [DATA_W-1:0]  s_data,
    input  logic               s_last,
    output logic               s_ready,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic [DATA_W-1:0]  rd_data,
    output logic               cnn_start,
    output logic               cnn_en,
    input  logic               cnn_done,
    input  logic [CLASS_W-1:0] cnn_class,
    output logic               res_valid,
    output logic [CLASS_W-1:0] res_class,
    input  logic               res_ready,
    output logic               frame_err,
    output logic [15:0]        frames_done
);

    feeder_state_t     state_q, state_d;
    logic [1:0]        full_q;
    logic              wr_bank_q;
    logic              rd_bank_q;
    logic [ADDR_W-1:0] wr_cnt_q;
    logic              accept;
    logic              frame_end;
    logic              commit;
    logic              rel_bank;
    logic              deliver;

    assign s_ready   = !full_q[wr_bank_q];
    assign accept    = s_valid && s_ready;
    assign frame_end = (wr_cnt_q == ADDR_W'(N - 1));
    assign commit    = accept && frame_end;
    assign deliver   = res_valid && res_ready;

    // A frame that reaches N pixels is always committed; s_last only decides the error flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_cnt_q  <= '0;
            wr_bank_q <= 1'b0;
            frame_err <= 1'b0;
        end else if (accept) begin
            if (frame_end) begin
                wr_cnt_q  <= '0;
                wr_bank_q <= !wr_bank_q;
                if (!s_last) begin
                    frame_err <= 1'b1;
                end
            end else if (s_last) begin
                wr_cnt_q  <= '0;
                frame_err <= 1'b1;
            end else begin
                wr_cnt_q <= wr_cnt_q + 1'b1;
            end
        end
    end

    // Writer and reader never own the same bank, so set and clear never collide.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full_q <= '0;
        end else begin
            if (commit) begin
                full_q[wr_bank_q] <= 1'b1;
            end
            if (rel_bank) begin
                full_q[rd_bank_q] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnn_start = 1'b0;
        cnn_en    = 1'b0;
        res_valid = 1'b0;
        rel_bank  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (full_q[rd_bank_q]) begin
                    state_d = START;
                end
            end
            START: begin
                cnn_start = 1'b1;
                state_d   = RUN;
            end
            RUN: begin
                cnn_en = 1'b1;
                if (cnn_done) begin
                    rel_bank = 1'b1;
                    state_d  = RESULT;
                end
            end
            RESULT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_bank_q   <= 1'b0;
            res_class   <= '0;
            frames_done <= '0;
        end else begin
            if (rel_bank) begin
                rd_bank_q <= !rd_bank_q;
                res_class <= cnn_class;
            end
            if (deliver) begin
                frames_done <= frames_done + 16'd1;
            end
        end
    end

    frame_bank_ram #(
        .DATA_W (DATA_W),
        .N      (N),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (accept),
        .wr_bank (wr_bank_q),
        .wr_addr (wr_cnt_q),
        .wr_data (s_data),
        .rd_bank (rd_bank_q),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_cnn_frame_feeder.sv
// Bench for cnn_frame_feeder: a 4x4 instance for protocol tests and a default 28x28 instance for reload.
module tb_cnn_frame_feeder;

    logic       clk = 1'b0;
    logic       rst, sel, s_valid, s_last, cnn_done, res_ready;
    logic [7:0] s_data;
    logic [9:0] rd_addr;
    logic [3:0] cnn_class;

    logic        a_s_ready, a_cnn_start, a_cnn_en, a_res_valid, a_frame_err;
    logic [7:0]  a_rd_data;
    logic [3:0]  a_res_class;
    logic [15:0] a_frames_done;
    logic        b_s_ready, b_cnn_start, b_cnn_en, b_res_valid, b_frame_err;
    logic [7:0]  b_rd_data;
    logic [3:0]  b_res_class;
    logic [15:0] b_frames_done;

    logic        o_s_ready, o_cnn_start, o_cnn_en, o_res_valid, o_frame_err;
    logic [7:0]  o_rd_data;
    logic [3:0]  o_res_class;
    logic [15:0] o_frames_done;

    // reference model: committed frames in arrival order, plus the frame being loaded
    logic [7:0]  fifo[$];
    logic [7:0]  cur[$];
    int          n_cur;
    bit          exp_err;
    logic [15:0] exp_fd;
    int          total, bad;

    always #5 clk = ~clk;

    cnn_frame_feeder #(.DATA_W(8), .IMG_W(4), .IMG_H(4), .CHANNELS(1), .CLASS_W(4)) u_small (
        .clk(clk), .rst(rst), .s_valid(s_valid && !sel), .s_data(s_data), .s_last(s_last),
        .s_ready(a_s_ready), .rd_addr(rd_addr[3:0]), .rd_data(a_rd_data),
        .cnn_start(a_cnn_start), .cnn_en(a_cnn_en), .cnn_done(cnn_done && !sel),
        .cnn_class(cnn_class), .res_valid(a_res_valid), .res_class(a_res_class),
        .res_ready(res_ready && !sel), .frame_err(a_frame_err), .frames_done(a_frames_done)
    );

    cnn_frame_feeder u_full (
        .clk(clk), .rst(rst), .s_valid(s_valid && sel), .s_data(s_data), .s_last(s_last),
        .s_ready(b_s_ready), .rd_addr(rd_addr), .rd_data(b_rd_data),
        .cnn_start(b_cnn_start), .cnn_en(b_cnn_en), .cnn_done(cnn_done && sel),
        .cnn_class(cnn_class), .res_valid(b_res_valid), .res_class(b_res_class),
        .res_ready(res_ready && sel), .frame_err(b_frame_err), .frames_done(b_frames_done)
    );

    assign o_s_ready     = sel ? b_s_ready     : a_s_ready;
    assign o_rd_data     = sel ? b_rd_data     : a_rd_data;
    assign o_cnn_start   = sel ? b_cnn_start   : a_cnn_start;
    assign o_cnn_en      = sel ? b_cnn_en      : a_cnn_en;
    assign o_res_valid   = sel ? b_res_valid   : a_res_valid;
    assign o_res_class   = sel ? b_res_class   : a_res_class;
    assign o_frame_err   = sel ? b_frame_err   : a_frame_err;
    assign o_frames_done = sel ? b_frames_done : a_frames_done;

    function automatic bit exp_ready();
        return fifo.size() < 2 * n_cur;
    endfunction

    task automatic model_reset();
        fifo.delete();
        cur.delete();
        exp_err = 1'b0;
        exp_fd  = '0;
    endtask

    task automatic push_pix(input logic [7:0] d, input logic l);
        int w = 0;
        s_valid = 1'b1; s_data = d; s_last = l;
        while (!o_s_ready && w < 400) begin
            @(negedge clk);
            w++;
        end
        if (!o_s_ready) begin
            total++; bad++;
            $display("FAIL push_timeout s_ready got=%0b required=1", o_s_ready);
            s_valid = 1'b0;
            return;
        end
        @(negedge clk);
        s_valid = 1'b0; s_last = 1'b0;
        cur.push_back(d);
        if (cur.size() == n_cur) begin
            for (int i = 0; i < cur.size(); i++) fifo.push_back(cur[i]);
            cur.delete();
            if (!l) exp_err = 1'b1;
        end else if (l) begin
            cur.delete();
            exp_err = 1'b1;
        end
    endtask

    task automatic push_frame(input int len, input bit last_ok, input bit ramp);
        for (int i = 0; i < len; i++)
            push_pix(ramp ? 8'(i) : 8'($urandom), last_ok && (i == len - 1));
    endtask

    // Core model: optional start check, reads, done pulse, result handshake after 'hold' stalls.
    task automatic core_frame(input logic [3:0] cls, input int hold, input bit wait_start,
                              input int nreads, input bit seq);
        int w = 0;
        int a;
        if (wait_start) begin
            while (!o_cnn_start && w < 100) begin
                @(negedge clk);
                w++;
            end
            total++;
            if (o_cnn_start !== 1'b1) begin
                bad++; $display("FAIL start_wait cnn_start got=%0b required=1", o_cnn_start);
            end
            @(negedge clk);
            total++;
            if ({o_cnn_start, o_cnn_en} !== 2'b01) begin
                bad++; $display("FAIL start_pulse start/en got=%b required=01", {o_cnn_start, o_cnn_en});
            end
        end else begin
            total++;
            if (o_cnn_en !== 1'b1) begin
                bad++; $display("FAIL run_en cnn_en got=%0b required=1", o_cnn_en);
            end
        end
        for (int i = 0; i < nreads; i++) begin
            a = seq ? i : $urandom_range(n_cur - 1, 0);
            rd_addr = 10'(a);
            @(negedge clk);
            total++;
            if (o_rd_data !== fifo[a]) begin
                bad++; $display("FAIL rd_data addr=%0d got=%0h required=%0h", a, o_rd_data, fifo[a]);
            end
        end
        cnn_done = 1'b1; cnn_class = cls;
        @(negedge clk);
        cnn_done = 1'b0; cnn_class = 4'($urandom);
        repeat (n_cur) void'(fifo.pop_front());
        total++;
        if ({o_res_valid, o_res_class, o_s_ready} !== {1'b1, cls, exp_ready()}) begin
            bad++;
            $display("FAIL result valid/class/ready got=%b/%0d/%b required=1/%0d/%b",
                     o_res_valid, o_res_class, o_s_ready, cls, exp_ready());
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            total++;
            if ({o_res_valid, o_res_class, o_cnn_start} !== {1'b1, cls, 1'b0}) begin
                bad++;
                $display("FAIL hold cyc=%0d valid/class/start got=%b/%0d/%b required=1/%0d/0",
                         i, o_res_valid, o_res_class, o_cnn_start, cls);
            end
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        exp_fd++;
        total++;
        if ({o_res_valid, o_frames_done} !== {1'b0, exp_fd}) begin
            bad++;
            $display("FAIL handshake valid/frames_done got=%b/%0d required=0/%0d",
                     o_res_valid, o_frames_done, exp_fd);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        total++;
        if ({o_s_ready, o_cnn_start, o_cnn_en, o_res_valid, o_frame_err} !== 5'b10000) begin
            bad++; $display("FAIL %s flags got=%b required=10000", tag,
                            {o_s_ready, o_cnn_start, o_cnn_en, o_res_valid, o_frame_err});
        end
        total++;
        if ({o_rd_data, o_res_class, o_frames_done} !== 28'd0) begin
            bad++; $display("FAIL %s data/class/count got=%0h/%0h/%0d required=0/0/0", tag,
                            o_rd_data, o_res_class, o_frames_done);
        end
    endtask

    task automatic test_reset();
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_load();
        push_frame(16, 1'b1, 1'b1);
        total++;
        if (o_cnn_start !== 1'b0) begin
            bad++; $display("FAIL start_early cnn_start got=%0b required=0", o_cnn_start);
        end
        @(negedge clk);
        total++;
        if (o_cnn_start !== 1'b1) begin
            bad++; $display("FAIL start_next cnn_start got=%0b required=1", o_cnn_start);
        end
        core_frame(4'd7, 0, 1'b1, 16, 1'b1);
    endtask

    task automatic test_ping_pong(input int hold);
        push_frame(16, 1'b1, 1'b0);
        push_frame(16, 1'b1, 1'b0);
        total++;
        if (o_s_ready !== exp_ready()) begin
            bad++; $display("FAIL both_full s_ready got=%0b required=%0b", o_s_ready, exp_ready());
        end
        core_frame(4'($urandom), hold, 1'b0, 12, 1'b0);
        core_frame(4'($urandom), 0, 1'b1, 12, 1'b0);
    endtask

    task automatic test_framing();
        for (int i = 0; i < 6; i++) push_pix(8'($urandom), i == 5);
        total++;
        if (o_frame_err !== exp_err) begin
            bad++; $display("FAIL short_err frame_err got=%0b required=%0b", o_frame_err, exp_err);
        end
        repeat (4) begin
            @(negedge clk);
            total++;
            if ({o_cnn_start, o_cnn_en} !== 2'b00) begin
                bad++; $display("FAIL dropped_start start/en got=%b required=00", {o_cnn_start, o_cnn_en});
            end
        end
        push_frame(16, 1'b1, 1'b0);
        core_frame(4'($urandom), 0, 1'b1, 16, 1'b0);
        push_frame(16, 1'b0, 1'b0);
        total++;
        if (o_frame_err !== exp_err) begin
            bad++; $display("FAIL nolast_err frame_err got=%0b required=%0b", o_frame_err, exp_err);
        end
        core_frame(4'($urandom), 0, 1'b1, 16, 1'b0);
    endtask

    task automatic test_reset_mid_run();
        int w = 0;
        int a;
        logic [9:0] oor[2];
        sel = 1'b1; n_cur = 784;
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        model_reset();
        @(negedge clk);
        push_frame(784, 1'b1, 1'b0);
        while (!o_cnn_en && w < 20) begin
            @(negedge clk);
            w++;
        end
        oor[0] = 10'd800; oor[1] = 10'd1023;
        for (int i = 0; i < 2; i++) begin
            rd_addr = oor[i];
            @(negedge clk);
            total++;
            if (o_rd_data !== 8'd0) begin
                bad++; $display("FAIL oor_read addr=%0d got=%0h required=0", oor[i], o_rd_data);
            end
        end
        a = $urandom_range(783, 0);
        rd_addr = 10'(a);
        @(negedge clk);
        total++;
        if (o_rd_data !== fifo[a] || o_cnn_en !== 1'b1) begin
            bad++; $display("FAIL run_read addr=%0d got=%0h/%b required=%0h/1", a, o_rd_data, o_cnn_en, fifo[a]);
        end
        rst = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        repeat (3) begin
            @(negedge clk);
            total++;
            if ({o_s_ready, o_cnn_start, o_cnn_en} !== 3'b100) begin
                bad++; $display("FAIL post_reset ready/start/en got=%b required=100",
                                {o_s_ready, o_cnn_start, o_cnn_en});
            end
        end
        push_frame(784, 1'b1, 1'b0);
        core_frame(4'($urandom), 1, 1'b1, 40, 1'b0);
    endtask

    initial begin
        rst = 1'b0; sel = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        rd_addr = '0; cnn_done = 1'b0; cnn_class = '0; res_ready = 1'b0;
        n_cur = 16; total = 0; bad = 0;
        model_reset();
        repeat (2) @(negedge clk);
        test_reset();
        test_load();
        test_ping_pong(2);
        test_ping_pong(20);
        test_framing();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog simulation time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
